// File: rtl/key_event_decoder.sv
// Key gesture decoder: press/release, short/double click, long press and optional auto-repeat.
// Define KEY_REPEAT_EN to enable auto-repeat strobes while the key is held past T_LONG.
module key_event_decoder #(
    parameter logic [24:0] T_LONG   = 25'd20_000_000,
    parameter logic [24:0] T_DOUBLE = 25'd5_000_000,
    parameter logic [24:0] T_REPEAT = 25'd2_000_000
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_click,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic busy
);

    localparam logic [2:0] S_IDLE           = 3'd0;
    localparam logic [2:0] S_PRESSED        = 3'd1;
    localparam logic [2:0] S_LONG_HELD      = 3'd2;
    localparam logic [2:0] S_WAIT_SECOND    = 3'd3;
    localparam logic [2:0] S_SECOND_PRESSED = 3'd4;

    localparam logic [24:0] CNT_MAX = '1;

    logic        key_meta_p0;
    logic        key_sync_p1;
    logic        key_prev_p2;
    logic [1:0]  fill;
    logic        armed;
    logic        fall;
    logic        rise;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [24:0] cnt;
    logic        cnt_clr;
    logic        press_nxt;
    logic        release_nxt;
    logic        short_nxt;
    logic        double_nxt;
    logic        long_nxt;
    logic        repeat_nxt;

    // Stage p0/p1: synchronizer; p2: delay flop for edge detection
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_p0 <= 1'b1;
            key_sync_p1 <= 1'b1;
            key_prev_p2 <= 1'b1;
            fill        <= 2'b00;
            armed       <= 1'b0;
        end else begin
            key_meta_p0 <= key_n;
            key_sync_p1 <= key_meta_p0;
            key_prev_p2 <= key_sync_p1;
            fill        <= {fill[0], 1'b1};
            // fill[1] marks that key_sync_p1 now carries a sampled key level, not the reset value
            armed       <= armed | (key_sync_p1 & fill[1]);
        end
    end

    assign fall = key_prev_p2 & ~key_sync_p1 & armed;
    assign rise = ~key_prev_p2 & key_sync_p1;

    always_comb begin
        state_nxt   = state;
        cnt_clr     = 1'b0;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        short_nxt   = 1'b0;
        double_nxt  = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall) begin
                    state_nxt = S_PRESSED;
                    press_nxt = 1'b1;
                end
            end
            S_PRESSED: begin
                // Release is checked first so a tie with the long threshold stays a click
                if (rise) begin
                    state_nxt   = S_WAIT_SECOND;
                    release_nxt = 1'b1;
                end else if (cnt == T_LONG - 25'd1) begin
                    state_nxt = S_LONG_HELD;
                    long_nxt  = 1'b1;
                end
            end
            S_LONG_HELD: begin
                if (rise) begin
                    state_nxt   = S_IDLE;
                    release_nxt = 1'b1;
                end
`ifdef KEY_REPEAT_EN
                else if (cnt == T_REPEAT - 25'd1) begin
                    repeat_nxt = 1'b1;
                    cnt_clr    = 1'b1;
                end
`endif
            end
            S_WAIT_SECOND: begin
                if (fall) begin
                    state_nxt = S_SECOND_PRESSED;
                    press_nxt = 1'b1;
                end else if (cnt == T_DOUBLE - 25'd1) begin
                    state_nxt = S_IDLE;
                    short_nxt = 1'b1;
                end
            end
            S_SECOND_PRESSED: begin
                if (rise) begin
                    state_nxt   = S_IDLE;
                    release_nxt = 1'b1;
                    double_nxt  = 1'b1;
                end else if (cnt == T_LONG - 25'd1) begin
                    state_nxt = S_LONG_HELD;
                    long_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage p3: state, counter and registered strobes
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_click   <= 1'b0;
            double_click  <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            state         <= state_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            short_click   <= short_nxt;
            double_click  <= double_nxt;
            long_press    <= long_nxt;
            if (state_nxt != state || cnt_clr)
                cnt <= '0;
`ifndef KEY_REPEAT_EN
            else if (state == S_LONG_HELD)
                cnt <= cnt;
`endif
            else if (state != S_IDLE && cnt != CNT_MAX)
                cnt <= cnt + 25'd1;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n)
            repeat_pulse <= 1'b0;
        else
            repeat_pulse <= repeat_nxt;
    end
`else
    assign repeat_pulse = 1'b0;
    logic unused_repeat;
    assign unused_repeat = repeat_nxt;
`endif

    assign busy = (state != S_IDLE);

endmodule
